// File: rtl/shreg_en.sv
// shreg_en: W-bit x DEPTH-stage enabled shift register with hold, shift-up, shift-down, clear,
// and a saturating fill count. Define SHREG_TAP_EN to add a combinational tap_sel/tap read port.
module shreg_en #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [W-1:0]                 d,
`ifdef SHREG_TAP_EN
  input  logic [$clog2(DEPTH)-1:0]     tap_sel,
  output logic [W-1:0]                 tap,
`endif
  output logic [W-1:0]                 q,
  output logic [W-1:0]                 q0,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  logic [W-1:0]  r_stage     [DEPTH];
  logic [W-1:0]  w_stage_nxt [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_full;

  // cnt only tracks how many shifts have happened, not their direction
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          for (int i = DEPTH-1; i >= 1; i--) begin
            w_stage_nxt[i] = r_stage[i-1];
          end
          w_stage_nxt[0] = d;
          w_cnt_nxt      = w_cnt_inc;
        end
        MODE_DOWN: begin
          for (int i = 0; i < DEPTH-1; i++) begin
            w_stage_nxt[i] = r_stage[i+1];
          end
          w_stage_nxt[DEPTH-1] = d;
          w_cnt_nxt            = w_cnt_inc;
        end
        MODE_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            w_stage_nxt[i] = '0;
          end
          w_cnt_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  // full is computed from the next count so it moves on the same edge as cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign q    = r_stage[DEPTH-1];
  assign q0   = r_stage[0];
  assign cnt  = r_cnt;
  assign full = r_full;

`ifdef SHREG_TAP_EN
  localparam int TW = $clog2(DEPTH);

  always_comb begin
    tap = '0;
    if ({1'b0, tap_sel} < (TW+1)'(DEPTH)) begin
      tap = r_stage[tap_sel];
    end
  end
`endif

endmodule

// File: tb/tb_shreg_en.sv
// tb_shreg_en: directed vector table plus randomized run against a queue-based reference model.
module tb_shreg_en;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int TW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [W-1:0]  q0;
  logic [CW-1:0] cnt;
  logic          full;
`ifdef SHREG_TAP_EN
  logic [TW-1:0] tap_sel;
  logic [W-1:0]  tap;
`endif

  shreg_en #(.W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .d       (d),
`ifdef SHREG_TAP_EN
    .tap_sel (tap_sel),
    .tap     (tap),
`endif
    .q       (q),
    .q0      (q0),
    .cnt     (cnt),
    .full    (full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: exp_q[i] is the expected content of stage i
  logic [W-1:0] exp_q[$];
  int           exp_cnt;
  int           n_pass;
  int           n_total;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] q0;
    int           cnt;
    logic         full;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
    exp_cnt = 0;
  endfunction

  function automatic void model_edge(input logic m_en, input logic [1:0] m_mode, input logic [W-1:0] m_d);
    if (!m_en) return;
    case (m_mode)
      2'b01: begin
        exp_q.push_front(m_d);
        void'(exp_q.pop_back());
        exp_cnt = (exp_cnt + 1 > DEPTH) ? DEPTH : exp_cnt + 1;
      end
      2'b10: begin
        exp_q.push_back(m_d);
        void'(exp_q.pop_front());
        exp_cnt = (exp_cnt + 1 > DEPTH) ? DEPTH : exp_cnt + 1;
      end
      2'b11: begin
        for (int i = 0; i < DEPTH; i++) exp_q[i] = '0;
        exp_cnt = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".q"},    32'(q),    32'(exp_q[DEPTH-1]));
    check({tag, ".q0"},   32'(q0),   32'(exp_q[0]));
    check({tag, ".cnt"},  32'(cnt),  32'(exp_cnt));
    check({tag, ".full"}, 32'(full), 32'(exp_cnt == DEPTH));
`ifdef SHREG_TAP_EN
    for (int s = 0; s < (1 << TW); s++) begin
      tap_sel = TW'(s);
      #0;
      check({tag, ".tap"}, 32'(tap), (s < DEPTH) ? 32'(exp_q[s]) : 32'd0);
    end
`endif
  endtask

  // driver: apply inputs, take one edge, update the model, sample 1 ns later
  task automatic drive(input logic t_en, input logic [1:0] t_mode, input logic [W-1:0] t_d);
    en   = t_en;
    mode = t_mode;
    d    = t_d;
    @(posedge clk);
    #1;
    model_edge(t_en, t_mode, t_d);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.q",    32'(q),    32'd0);
    check("async_rst.q0",   32'(q0),   32'd0);
    check("async_rst.cnt",  32'(cnt),  32'd0);
    check("async_rst.full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    // vector table: {en, mode, d, q, q0, cnt, full} after the edge
    vecs[0]  = '{1'b1, 2'b01, 8'h11, 8'h00, 8'h11, 1, 1'b0};
    vecs[1]  = '{1'b1, 2'b01, 8'h22, 8'h00, 8'h22, 2, 1'b0};
    vecs[2]  = '{1'b1, 2'b01, 8'h33, 8'h00, 8'h33, 3, 1'b0};
    vecs[3]  = '{1'b1, 2'b01, 8'h44, 8'h11, 8'h44, 4, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 8'h55, 8'h22, 8'h55, 4, 1'b1};
    vecs[5]  = '{1'b0, 2'b01, 8'hAA, 8'h22, 8'h55, 4, 1'b1};
    vecs[6]  = '{1'b0, 2'b01, 8'hAA, 8'h22, 8'h55, 4, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 8'hAA, 8'h22, 8'h55, 4, 1'b1};
    vecs[8]  = '{1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 0, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 8'h11, 8'h11, 8'h00, 1, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 8'h22, 8'h22, 8'h00, 2, 1'b0};
    vecs[11] = '{1'b1, 2'b10, 8'h33, 8'h33, 8'h00, 3, 1'b0};
    vecs[12] = '{1'b1, 2'b10, 8'h44, 8'h44, 8'h11, 4, 1'b1};
    vecs[13] = '{1'b1, 2'b10, 8'h99, 8'h99, 8'h22, 4, 1'b1};
    vecs[14] = '{1'b1, 2'b00, 8'h77, 8'h99, 8'h22, 4, 1'b1};
    vecs[15] = '{1'b1, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 1'b0};
    vecs[16] = '{1'b1, 2'b01, 8'h5A, 8'h00, 8'h5A, 1, 1'b0};
    vecs[17] = '{1'b1, 2'b10, 8'hA5, 8'hA5, 8'h00, 2, 1'b0};

    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    d     = '0;
`ifdef SHREG_TAP_EN
    tap_sel = '0;
`endif
    model_reset();
    #1;
    check("reset.q",    32'(q),    32'd0);
    check("reset.q0",   32'(q0),   32'd0);
    check("reset.cnt",  32'(cnt),  32'd0);
    check("reset.full", 32'(full), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].en, vecs[v].mode, vecs[v].d);
      check($sformatf("vec%0d.q", v),    32'(q),    32'(vecs[v].q));
      check($sformatf("vec%0d.q0", v),   32'(q0),   32'(vecs[v].q0));
      check($sformatf("vec%0d.cnt", v),  32'(cnt),  32'(vecs[v].cnt));
      check($sformatf("vec%0d.full", v), 32'(full), 32'(vecs[v].full));
    end

    // asynchronous reset mid-cycle with loaded stages, no clock edge needed
    drive(1'b1, 2'b01, 8'hC3);
    async_reset();

    // tap read after loading 11,22,33,44 by shift-up
    drive(1'b1, 2'b01, 8'h11);
    drive(1'b1, 2'b01, 8'h22);
    drive(1'b1, 2'b01, 8'h33);
    drive(1'b1, 2'b01, 8'h44);
`ifdef SHREG_TAP_EN
    tap_sel = TW'(0);
    #0;
    check("tap_sel0", 32'(tap), 32'h44);
    tap_sel = TW'(3);
    #0;
    check("tap_sel3", 32'(tap), 32'h11);
`endif
    check_model("load");

    // randomized run against the reference model, with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset();
        check_model("rnd_rst");
      end else begin
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), W'($urandom));
        check_model("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
